// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I main control unit. Decodes the D-stage opcode, carries the
// write-side controls down a STAGES-deep control pipe, and handles load-use stalls,
// branch flush bubbles, external hold and illegal-opcode detection.
// Optional feature macro: CSR_SUPPORT_EN (adds the csr_f3_D input and SYSTEM/CSR decode).
module pipe_ctrl_unit #(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic       clk_o,
    input  logic       reset,
    input  logic       valid_D,
    input  logic [6:0] opcode_D,
    input  logic [4:0] rd_D,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
`ifdef CSR_SUPPORT_EN
    input  logic [2:0] csr_f3_D,
`endif
    input  logic       stall_ext,
    input  logic       flush,
    output logic       alu_op,
    output logic       sel_A,
    output logic       sel_B,
    output logic       reg_wr_W,
    output logic       cs_W,
    output logic       wr_W,
    output logic [1:0] wb_sel_W,
    output logic       csr_rd_W,
    output logic       csr_wr_W,
    output logic       stall_D,
    output logic       illegal_D
);

    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef CSR_SUPPORT_EN
    localparam logic [6:0] OP_SYS   = 7'b1110011;
`endif

    // Write-side controls carried from decode to W; cs is active-low.
    typedef struct packed {
        logic       reg_wr;
        logic       cs;
        logic       wr;
        logic [1:0] wb_sel;
`ifdef CSR_SUPPORT_EN
        logic       csr_rd;
        logic       csr_wr;
`endif
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{cs: 1'b1, default: '0};

    typedef enum logic {RUN = 1'b0, HAZ = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              pipe_q [STAGES];
    logic               ld1_q;
    logic [4:0]         ld_rd1_q;

    ctrl_t              dec;
    logic               dec_load;
    logic               unknown;
    logic               bubble_in;
    logic               haz_det;

    // Opcode decode; invalid or unknown instructions collapse to a bubble.
    always_comb begin
        dec      = BUBBLE;
        dec_load = 1'b0;
        unknown  = 1'b0;
        alu_op   = 1'b0;
        sel_A    = 1'b0;
        sel_B    = 1'b0;
        case (opcode_D)
            OP_R: begin
                alu_op     = 1'b1;
                dec.reg_wr = 1'b1;
            end
            OP_I: begin
                alu_op     = 1'b1;
                dec.reg_wr = 1'b1;
                sel_B      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b01;
                dec.cs     = 1'b0;
                sel_B      = 1'b1;
                dec_load   = 1'b1;
            end
            OP_STORE: begin
                dec.wr = 1'b1;
                dec.cs = 1'b0;
                sel_B  = 1'b1;
            end
            OP_BR: begin
                sel_A = 1'b1;
                sel_B = 1'b1;
            end
            OP_JAL: begin
                dec.wb_sel = 2'b10;
                dec.reg_wr = 1'b1;
                sel_A      = 1'b1;
                sel_B      = 1'b1;
            end
            OP_JALR: begin
                dec.wb_sel = 2'b10;
                dec.reg_wr = 1'b1;
                sel_B      = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_wr = 1'b1;
                sel_A      = 1'b1;
                sel_B      = 1'b1;
            end
            OP_LUI: begin
                dec.reg_wr = 1'b1;
                sel_B      = 1'b1;
            end
`ifdef CSR_SUPPORT_EN
            OP_SYS: begin
                dec.reg_wr = 1'b1;
                dec.wb_sel = 2'b11;
                dec.csr_rd = 1'b1;
                dec.csr_wr = (csr_f3_D != 3'b000);
            end
`endif
            default: unknown = 1'b1;
        endcase
        if (!valid_D || unknown) begin
            dec      = BUBBLE;
            dec_load = 1'b0;
            alu_op   = 1'b0;
            sel_A    = 1'b0;
            sel_B    = 1'b0;
        end
    end

    assign illegal_D = valid_D & unknown;

    // Load in stage 1 whose destination is read by the D instruction.
    assign haz_det = ld1_q && (ld_rd1_q != 5'd0) && valid_D &&
                     ((ld_rd1_q == rs1_D) || (ld_rd1_q == rs2_D));

    // Hazard FSM next state, stall and bubble selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_D   = 1'b0;
        bubble_in = 1'b0;
        if (stall_ext) begin
            stall_D = 1'b1;
        end else if (flush) begin
            state_d   = RUN;
            cnt_d     = '0;
            bubble_in = 1'b1;
        end else if (state_q == HAZ) begin
            stall_D   = 1'b1;
            bubble_in = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (haz_det) begin
            // The detection cycle is the first stall cycle; HAZ covers the rest.
            stall_D   = 1'b1;
            bubble_in = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = HAZ;
                cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
        end
    end

    // FSM state and stall counter.
    always_ff @(posedge clk_o or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control pipe shift; frozen while stall_ext is high.
    always_ff @(posedge clk_o or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                pipe_q[i] <= BUBBLE;
            end
            ld1_q    <= 1'b0;
            ld_rd1_q <= 5'd0;
        end else if (!stall_ext) begin
            pipe_q[0] <= bubble_in ? BUBBLE : dec;
            ld1_q     <= !bubble_in && dec_load;
            ld_rd1_q  <= rd_D;
            for (int i = 1; i < int'(STAGES); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign reg_wr_W = pipe_q[STAGES-1].reg_wr;
    assign cs_W     = pipe_q[STAGES-1].cs;
    assign wr_W     = pipe_q[STAGES-1].wr;
    assign wb_sel_W = pipe_q[STAGES-1].wb_sel;
`ifdef CSR_SUPPORT_EN
    assign csr_rd_W = pipe_q[STAGES-1].csr_rd;
    assign csr_wr_W = pipe_q[STAGES-1].csr_wr;
`else
    assign csr_rd_W = 1'b0;
    assign csr_wr_W = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of stall/flush/bubble rules.
module tb_pipe_ctrl_unit;

    localparam int unsigned STAGES   = 2;
    localparam int unsigned LOAD_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_D = 1'b0;
    logic [6:0] opcode_D = 7'd0;
    logic [4:0] rd_D = 5'd0, rs1_D = 5'd0, rs2_D = 5'd0;
    logic [2:0] f3_D = 3'd0;
    logic       stall_ext = 1'b0, flush = 1'b0;
    logic       alu_op, sel_A, sel_B, reg_wr_W, cs_W, wr_W, csr_rd_W, csr_wr_W;
    logic       stall_D, illegal_D;
    logic [1:0] wb_sel_W;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.STAGES(STAGES), .LOAD_LAT(LOAD_LAT)) dut (
        .clk_o(clk), .reset(reset), .valid_D(valid_D), .opcode_D(opcode_D),
        .rd_D(rd_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
`ifdef CSR_SUPPORT_EN
        .csr_f3_D(f3_D),
`endif
        .stall_ext(stall_ext), .flush(flush),
        .alu_op(alu_op), .sel_A(sel_A), .sel_B(sel_B),
        .reg_wr_W(reg_wr_W), .cs_W(cs_W), .wr_W(wr_W), .wb_sel_W(wb_sel_W),
        .csr_rd_W(csr_rd_W), .csr_wr_W(csr_wr_W),
        .stall_D(stall_D), .illegal_D(illegal_D)
    );

    typedef struct packed {
        logic       reg_wr;
        logic       cs;
        logic       wr;
        logic [1:0] wb;
        logic       csr_rd;
        logic       csr_wr;
    } w_t;

    typedef struct packed {
        logic alu;
        logic sa;
        logic sb;
        logic stall;
        logic ill;
    } c_t;

    localparam w_t W_BUB = '{cs: 1'b1, default: '0};

    w_t   w_q[$];
    c_t   c_q[$];
    w_t   cur_w;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic mon_adv;

    int         stall_left;
    logic       last_load;
    logic [4:0] last_rd;
    logic       pred_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic void ref_decode(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                       output w_t w, output c_t c, output logic ld);
        logic known;
        w = W_BUB; c = '0; ld = 1'b0; known = 1'b1;
        case (op)
            7'b0110011: begin c.alu = 1; w.reg_wr = 1; end
            7'b0010011: begin c.alu = 1; w.reg_wr = 1; c.sb = 1; end
            7'b0000011: begin w.reg_wr = 1; w.wb = 2'b01; c.sb = 1; w.cs = 0; ld = 1; end
            7'b0100011: begin w.wr = 1; c.sb = 1; w.cs = 0; end
            7'b1100011: begin c.sa = 1; c.sb = 1; end
            7'b1101111: begin w.wb = 2'b10; w.reg_wr = 1; c.sa = 1; c.sb = 1; end
            7'b1100111: begin w.wb = 2'b10; w.reg_wr = 1; c.sb = 1; end
            7'b0010111: begin c.sa = 1; c.sb = 1; w.reg_wr = 1; end
            7'b0110111: begin c.sb = 1; w.reg_wr = 1; end
`ifdef CSR_SUPPORT_EN
            7'b1110011: begin w.reg_wr = 1; w.wb = 2'b11; w.csr_rd = 1; w.csr_wr = (f3 != 0); end
`endif
            default: known = 1'b0;
        endcase
        c.ill = v && !known;
        if (!v || !known) begin
            w = W_BUB; c.alu = 0; c.sa = 0; c.sb = 0; ld = 1'b0;
        end
    endfunction

    // Predict the coming clock edge from the current inputs and queue expectations.
    task automatic model_step();
        w_t   w, ent;
        c_t   c;
        logic ld, ent_ld, stall;
        ref_decode(valid_D, opcode_D, f3_D, w, c, ld);
        stall = 1'b0; ent = W_BUB; ent_ld = 1'b0;
        if (stall_ext) begin
            stall = 1'b1;
        end else if (flush) begin
            stall_left = 0;
        end else if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else if (valid_D && last_load && last_rd != 0 && (last_rd == rs1_D || last_rd == rs2_D)) begin
            stall = 1'b1;
            stall_left = int'(LOAD_LAT) - 1;
        end else begin
            ent = w; ent_ld = ld;
        end
        c.stall = stall;
        c_q.push_back(c);
        if (!stall_ext) begin
            w_q.push_back(ent);
            last_load = ent_ld;
            last_rd   = rd_D;
        end
        pred_stall = stall;
    endtask

    task automatic model_reset();
        w_q.delete();
        c_q.delete();
        for (int i = 0; i < int'(STAGES) - 1; i++) w_q.push_back(W_BUB);
        cur_w = W_BUB;
        stall_left = 0;
        last_load = 1'b0;
        last_rd = 5'd0;
        pred_stall = 1'b0;
    endtask

    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [2:0] f3, input logic se, input logic fl);
        @(negedge clk);
        valid_D = v; opcode_D = op; rd_D = rd; rs1_D = r1; rs2_D = r2; f3_D = f3;
        stall_ext = se; flush = fl;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_stall_D", 32'(stall_D), 32'd0);
        check("rst_w_out", 32'({reg_wr_W, cs_W, wr_W, wb_sel_W, csr_rd_W, csr_wr_W}), 32'(W_BUB));
        valid_D = 1'b0; opcode_D = 7'd0; rd_D = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
        f3_D = 3'd0; stall_ext = 1'b0; flush = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        model_step();
        mon_en = 1'b1;
    endtask

    // W-side monitor: new expectation on each advancing edge, held value otherwise.
    always @(posedge clk) begin
        mon_adv = !stall_ext && !reset;
        #1;
        if (mon_en) begin
            if (mon_adv) begin
                if (w_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_queue at %0t: got empty queue expected entry", $time);
                end else begin
                    cur_w = w_q.pop_front();
                end
            end
            check("w_out", 32'({reg_wr_W, cs_W, wr_W, wb_sel_W, csr_rd_W, csr_wr_W}), 32'(cur_w));
        end
    end

    // D-side monitor for the combinational outputs.
    always @(negedge clk) begin
        c_t c;
        #4;
        if (mon_en && c_q.size() > 0) begin
            c = c_q.pop_front();
            check("d_comb", 32'({alu_op, sel_A, sel_B, stall_D, illegal_D}), 32'(c));
        end
    end

    logic [6:0] ops [12];

    initial begin
        logic [6:0] op;
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        logic       v;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0010111;
        ops[8] = 7'b0110111; ops[9] = 7'b1110011; ops[10] = 7'b0000011; ops[11] = 7'b1111111;

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // R-type through the pipe
        issue(1, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0);
        idle(3);
        // load-use: LOAD x5, then dependent ADD held for LOAD_LAT cycles
        issue(1, 7'b0000011, 5'd5, 5'd1, 5'd0, 3'd0, 0, 0);
        repeat (3) issue(1, 7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0, 0, 0);
        idle(3);
        // reset during the hazard stall
        issue(1, 7'b0000011, 5'd5, 5'd1, 5'd0, 3'd0, 0, 0);
        issue(1, 7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0, 0, 0);
        do_reset();
        idle(2);
        // load to x0 never stalls
        issue(1, 7'b0000011, 5'd0, 5'd1, 5'd0, 3'd0, 0, 0);
        issue(1, 7'b0110011, 5'd4, 5'd0, 5'd0, 3'd0, 0, 0);
        // flush wins over a concurrent hazard
        issue(1, 7'b0000011, 5'd3, 5'd1, 5'd0, 3'd0, 0, 0);
        issue(1, 7'b0110011, 5'd4, 5'd3, 5'd0, 3'd0, 0, 1);
        idle(3);
        // store held by external stall
        issue(1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd0, 0, 0);
        repeat (3) issue(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1, 1);
        idle(3);
        // SYSTEM opcode, with and without a CSR write
        issue(1, 7'b1110011, 5'd7, 5'd1, 5'd0, 3'b001, 0, 0);
        issue(1, 7'b1110011, 5'd7, 5'd1, 5'd0, 3'b000, 0, 0);
        idle(3);

        // random traffic; D is held while the model predicts a stall
        op = 7'd0; rd = 5'd0; r1 = 5'd0; r2 = 5'd0; f3 = 3'd0; v = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!pred_stall || flush) begin
                v  = ($urandom_range(0, 9) != 0);
                op = ops[$urandom_range(0, 11)];
                if (op == 7'b1111111) op = 7'($urandom);
                rd = 5'($urandom_range(0, 3));
                r1 = 5'($urandom_range(0, 3));
                r2 = 5'($urandom_range(0, 3));
                f3 = 3'($urandom_range(0, 7));
            end
            issue(v, op, rd, r1, r2, f3,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        idle(4);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
